// File: rtl/alu_pkg.sv
// Shared types and constants for the execute-stage ALU.
package alu_pkg;

    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLL  = 4'h2,
        ALU_SLT  = 4'h3,
        ALU_SLTU = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SRA  = 4'h6,
        ALU_SRL  = 4'h7,
        ALU_OR   = 4'h8,
        ALU_AND  = 4'h9,
        ALU_BEQ  = 4'hA,
        ALU_BNE  = 4'hB,
        ALU_BGE  = 4'hC,
        ALU_BGEU = 4'hD
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/serial_shifter.sv
// One-bit-per-cycle shifter. Loads data/shamt, then shifts until its counter drains.
module serial_shifter
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [31:0]        data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,    // 0 = left, 1 = right
    input  logic               arith,  // right shifts fill with bit 31
    output logic [31:0]        q,      // register value after this cycle's shift
    output logic               last    // this cycle performs the final shift
);

    logic [31:0]        sr_q, sr_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               arith_q, arith_d;
    logic [31:0]        step;

    // Single-bit shift of the held value in the latched direction.
    always_comb begin
        if (dir_q) begin
            step = {arith_q & sr_q[31], sr_q[31:1]};
        end else begin
            step = {sr_q[30:0], 1'b0};
        end
    end

    // Load on request, otherwise shift while the counter is non-zero.
    always_comb begin
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        if (load) begin
            sr_d    = data;
            cnt_d   = shamt;
            dir_d   = dir;
            arith_d = arith;
        end else if (cnt_q != '0) begin
            sr_d  = step;
            cnt_d = cnt_q - SHAMT_W'(1);
        end
    end

    // Shifter state registers; reset aborts any shift in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end

    assign q    = step;
    assign last = (cnt_q == SHAMT_W'(1)) && !load;

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle arithmetic/logic/compare, optional serial shifts.
module alu_exec
    import alu_pkg::*;
#(
    parameter int unsigned SERIAL_SHIFT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  aluControl,
    input  logic        isShamt,
    input  logic        isBranch,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic [31:0] result,
    output logic        branchTaken,
    output logic        busy,
    output logic        done
);

    localparam bit UseSerial = (SERIAL_SHIFT != 0);

    alu_state_t         state_q, state_d;
    logic [31:0]        result_q, result_d;
    logic               branch_q, branch_d;
    logic [31:0]        alu_res;
    logic               cond, is_cmp, is_shift, sh_load, sh_last;
    logic [31:0]        sh_q;
    logic [SHAMT_W-1:0] shamt;
    logic               unused_is_shamt;

    // The shift amount always comes from srcB[4:0], so isShamt carries no extra information.
    assign unused_is_shamt = isShamt;
    assign shamt           = srcB[SHAMT_W-1:0];

    // Combinational datapath; shifts here serve shamt=0 and the non-serial build.
    always_comb begin
        alu_res  = '0;
        cond     = 1'b0;
        is_cmp   = 1'b0;
        is_shift = 1'b0;
        case (alu_op_t'(aluControl))
            ALU_ADD:  alu_res = srcA + srcB;
            ALU_SUB:  alu_res = srcA - srcB;
            ALU_XOR:  alu_res = srcA ^ srcB;
            ALU_OR:   alu_res = srcA | srcB;
            ALU_AND:  alu_res = srcA & srcB;
            ALU_SLL: begin alu_res = srcA << shamt; is_shift = 1'b1; end
            ALU_SRL: begin alu_res = srcA >> shamt; is_shift = 1'b1; end
            ALU_SRA: begin
                alu_res  = $unsigned($signed(srcA) >>> shamt);
                is_shift = 1'b1;
            end
            ALU_SLT:  begin cond = $signed(srcA) < $signed(srcB);   is_cmp = 1'b1; end
            ALU_SLTU: begin cond = srcA < srcB;                     is_cmp = 1'b1; end
            ALU_BEQ:  begin cond = srcA == srcB;                    is_cmp = 1'b1; end
            ALU_BNE:  begin cond = srcA != srcB;                    is_cmp = 1'b1; end
            ALU_BGE:  begin cond = $signed(srcA) >= $signed(srcB);  is_cmp = 1'b1; end
            ALU_BGEU: begin cond = srcA >= srcB;                    is_cmp = 1'b1; end
            default:  alu_res = '0;
        endcase
        if (is_cmp) begin
            alu_res = {31'd0, cond};
        end
    end

    generate
        if (UseSerial) begin : g_serial
            serial_shifter u_shifter (
                .clk   (clk),
                .rst   (reset),
                .load  (sh_load),
                .data  (srcA),
                .shamt (shamt),
                .dir   (alu_op_t'(aluControl) != ALU_SLL),
                .arith (alu_op_t'(aluControl) == ALU_SRA),
                .q     (sh_q),
                .last  (sh_last)
            );
        end else begin : g_comb
            assign sh_q    = '0;
            assign sh_last = 1'b0;
        end
    endgenerate

    // State and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            branch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            branch_q <= branch_d;
        end
    end

    // Next-state and result capture; start is only honoured in IDLE.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        branch_d = branch_q;
        sh_load  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_shift && UseSerial && (shamt != '0)) begin
                        sh_load = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        result_d = alu_res;
                        branch_d = isBranch & is_cmp & cond;
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                if (sh_last) begin
                    result_d = sh_q;
                    branch_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        busy = (state_q == SHIFT);
        done = (state_q == DONE);
    end

    assign result      = result_q;
    assign branchTaken = branch_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec against a cycle-count behavioural model.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  aluControl = 4'h0;
    logic        isShamt = 1'b0;
    logic        isBranch = 1'b0;
    logic [31:0] srcA = '0;
    logic [31:0] srcB = '0;
    logic [31:0] result;
    logic        branchTaken, busy, done;

    int n_chk = 0;
    int n_pass = 0;

    alu_exec #(.SERIAL_SHIFT(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .aluControl  (aluControl),
        .isShamt     (isShamt),
        .isBranch    (isBranch),
        .srcA        (srcA),
        .srcB        (srcB),
        .result      (result),
        .branchTaken (branchTaken),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: what an op produces and how many cycles until done.
    function automatic void model_op(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, input logic br,
                                     output logic [31:0] r, output logic t, output int lat);
        int s;
        logic c;
        bit cmp;
        s   = int'(b[4:0]);
        r   = 32'd0;
        c   = 1'b0;
        cmp = 1'b0;
        lat = 1;
        case (op)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: begin r = a << s; lat = (s == 0) ? 1 : s + 1; end
            4'h3: begin c = $signed(a) < $signed(b); cmp = 1'b1; end
            4'h4: begin c = a < b; cmp = 1'b1; end
            4'h5: r = a ^ b;
            4'h6: begin r = $unsigned($signed(a) >>> s); lat = (s == 0) ? 1 : s + 1; end
            4'h7: begin r = a >> s; lat = (s == 0) ? 1 : s + 1; end
            4'h8: r = a | b;
            4'h9: r = a & b;
            4'hA: begin c = (a == b); cmp = 1'b1; end
            4'hB: begin c = (a != b); cmp = 1'b1; end
            4'hC: begin c = $signed(a) >= $signed(b); cmp = 1'b1; end
            4'hD: begin c = a >= b; cmp = 1'b1; end
            default: r = 32'd0;
        endcase
        if (cmp) r = {31'd0, c};
        t = cmp & br & c;
    endfunction

    // Model state: an accepted op ages one per cycle; done when age reaches latency.
    bit          m_active = 1'b0;
    int          m_age = 0;
    int          p_lat = 1;
    logic [31:0] p_res = '0;
    logic        p_br = 1'b0;
    logic [31:0] m_res = '0;
    logic        m_br = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_active = 1'b0;
                m_res    = '0;
                m_br     = 1'b0;
            end else begin
                if (!m_active) begin
                    if (start) begin
                        model_op(aluControl, srcA, srcB, isBranch, p_res, p_br, p_lat);
                        m_active = 1'b1;
                        m_age    = 1;
                    end
                end else if (m_age == p_lat) begin
                    m_active = 1'b0;
                end else begin
                    m_age++;
                end
                if (m_active && m_age == p_lat) begin
                    m_res = p_res;
                    m_br  = p_br;
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_done", 32'(done), 32'(m_active && m_age == p_lat));
            chk("cyc_busy", 32'(busy), 32'(m_active && m_age < p_lat));
            chk("cyc_result", result, m_res);
            chk("cyc_branch", 32'(branchTaken), 32'(m_br));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Issue one op, scramble inputs while it runs, wait for done; optionally check literals.
    task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic br, input bit lit, input logic [31:0] er, input logic eb,
                       input int el, input string nm);
        int n;
        bit got;
        logic [31:0] mr;
        logic mt;
        int ml;
        model_op(op, a, b, br, mr, mt, ml);
        aluControl = op;
        srcA       = a;
        srcB       = b;
        isBranch   = br;
        isShamt    = $urandom_range(0, 1) == 1;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        srcA       = $urandom;
        srcB       = $urandom;
        aluControl = 4'($urandom_range(0, 15));
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
        end else if (lit) begin
            chk({nm, "_lat"}, 32'(n), 32'(el));
            chk({nm, "_res"}, result, er);
            chk({nm, "_br"}, 32'(branchTaken), 32'(eb));
        end else begin
            chk({nm, "_lat"}, 32'(n), 32'(ml));
            chk({nm, "_res"}, result, mr);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dones;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_result", result, 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        tick();

        // Hand-computed expectations.
        run(4'h0, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b1, 32'h0, 1'b0, 1, "add_wrap");
        run(4'h1, 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1, "sub");
        run(4'h3, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 32'd1, 1'b0, 1, "slt");
        run(4'h4, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 32'd0, 1'b0, 1, "sltu");
        run(4'h6, 32'h80000000, 32'd31, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32, "sra31");
        run(4'h7, 32'h80000000, 32'd31, 1'b0, 1'b1, 32'h00000001, 1'b0, 32, "srl31");
        run(4'h2, 32'h1234, 32'd0, 1'b0, 1'b1, 32'h1234, 1'b0, 1, "sll0");
        run(4'h2, 32'h1, 32'd4, 1'b0, 1'b1, 32'h10, 1'b0, 5, "sll4");
        run(4'h3, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b1, 32'd1, 1'b1, 1, "blt");
        run(4'hD, 32'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 32'd0, 1'b0, 1, "bgeu");
        run(4'hB, 32'd4, 32'd4, 1'b1, 1'b1, 32'd0, 1'b0, 1, "bne");
        run(4'hA, 32'd4, 32'd4, 1'b0, 1'b1, 32'd1, 1'b0, 1, "beq_nobr");
        run(4'hC, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b1, 1'b1, 32'd1, 1'b1, 1, "bge_eq");
        run(4'hE, 32'd3, 32'd3, 1'b1, 1'b1, 32'd0, 1'b0, 1, "reserved");

        // A start during a shift is ignored; exactly one done with the shift result.
        aluControl = 4'h7;
        srcA       = 32'hF0000000;
        srcB       = 32'd10;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        aluControl = 4'h0;
        srcA       = 32'd1;
        srcB       = 32'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        n     = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (done) begin
                dones++;
                chk("ignore_lat", 32'(n + 2), 32'd11);
                chk("ignore_res", result, 32'h003C0000);
            end
        end
        chk("ignore_dones", 32'(dones), 32'd1);
        tick();

        // Reset in the middle of a shift.
        run(4'h0, 32'd1, 32'd2, 1'b0, 1'b1, 32'd3, 1'b0, 1, "pre_reset_add");
        aluControl = 4'h7;
        srcA       = 32'hFFFFFFFF;
        srcB       = 32'd20;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        tick();
        reset = 1'b0;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rst_no_done", 32'(dones), 32'd0);
        tick();
        run(4'h0, 32'd10, 32'd20, 1'b0, 1'b1, 32'd30, 1'b0, 1, "post_reset_add");

        // Randomized ops; shifts favour small and edge amounts.
        for (int i = 0; i < 200; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 3))
                0: b = a;
                1: b[4:0] = 5'($urandom_range(0, 3));
                2: a = {1'b1, a[30:0]};
                default: ;
            endcase
            run(op, a, b, 1'($urandom_range(0, 1)), 1'b0, 32'd0, 1'b0, 0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
